register_file: RTL
==================

# register_file

Integer register file for the pipeline: 32 × 32-bit architectural registers with two synchronous read ports, one write-back port and a pending-write scoreboard. Decode presents read addresses, and the data returns one cycle later as `rdata1`/`rdata2` for the forwarding stage. Execute/write-back retires results through the write port. Long-latency writers (load, divide) reserve their destination so that decode can stall on `busy1`/`busy2`.

## Interface
Parameters:
- none; geometry is fixed at 32 registers × 32 bits, or 16 × 32 with `RV32E_EN` (see Configuration).

Ports (one clock; reset is asynchronous and active-low):
- `reset`  in  1  asynchronous, active-low reset
- `clock`  in  1  rising-edge clock
- `rden1`  in  1  read enable, port 1
- `raddr1`  in  5  read address, port 1
- `rden2`  in  1  read enable, port 2
- `raddr2`  in  5  read address, port 2
- `rdata1`  out  32  registered read data, port 1
- `rdata2`  out  32  registered read data, port 2
- `wren`  in  1  write-back enable
- `waddr`  in  5  write-back address
- `wdata`  in  32  write-back data
- `rsv_en`  in  1  reserve destination of an issued long-latency op
- `rsv_addr`  in  5  register to reserve
- `busy1`  out  1  combinational: port-1 source has a pending write
- `busy2`  out  1  combinational: port-2 source has a pending write

## Operation
- **Storage:** `regs[1..31]`. x0 always reads 0. Writes to x0 are discarded.
- **Write:** on a rising edge with `wren=1` and `waddr≠0`, `regs[waddr] <= wdata`.
- **Read (per port n):** on a rising edge,
  - `rden_n=0`: `rdata_n <= 0`.
  - `raddr_n=0`: `rdata_n <= 0`.
  - Same-cycle write to the same address (`wren=1`, `waddr=raddr_n≠0`): `rdata_n <= wdata` (write-first bypass).
  - Otherwise: `rdata_n <= regs[raddr_n]`.
- **Scoreboard:** 32 pending bits `sb[]`, all clear at reset. `sb[0]` is never set.
  - On a rising edge, `wren=1` clears `sb[waddr]`.
  - On a rising edge, `rsv_en=1` with `rsv_addr≠0` sets `sb[rsv_addr]`.
  - If both target the same address in one cycle, the reservation wins and the bit ends set. That write belongs to the older producer, and a newer writer is now pending.
  - Reserving an address that is already pending leaves it set; no counting.
- **Busy:** `busy_n = rden_n & sb[raddr_n] & ~(wren & waddr==raddr_n)`. A write landing this cycle clears the hazard combinationally, and the bypassed value appears on `rdata_n` next cycle. `raddr_n=0` never reports busy.
- The block has no error or illegal outputs. Out-of-range handling is defined under Configuration.

## Timing
- **Reset:** while `reset=0`, all regs = 0, sb = 0, `rdata1`/`rdata2` = 0. `busy1`/`busy2` = 0 because sb is clear. Reset is asynchronous and takes effect mid-cycle, discarding in-flight writes and reservations.
- **Read latency:** 1 cycle from address to `rdata`. Reads are fully pipelined; a new address is accepted every cycle.
- **Write latency:** 0-cycle visibility through the bypass. The value is stored at the edge.
- **Busy:** combinational from inputs and sb, with no registered delay. Decode must hold `raddr` stable while it stalls. `rdata` then re-reads every cycle and picks up the write-back through the bypass.
- Both read ports may address the same register. Both return identical data.

## Configuration
- **`RV32E_EN` defined:** 16 registers (x0–x15).
  - Writes with `waddr[4]=1` are ignored.
  - Reads with `raddr_n[4]=1` return 0.
  - Reservations with `rsv_addr[4]=1` are ignored, and busy is 0 for those addresses.
  - Storage and scoreboard shrink to 15 and 16 entries.
- **`RV32E_EN` undefined:** full 32-register behaviour as above.

## Test plan
- **Reset:** assert `reset=0` mid-run after writing x5=0x1234 → `rdata1`=0 immediately. After release, reading x5 → 0.
- **Write/read and x0:** write x7=0xDEADBEEF, then next cycle read x7 on both ports → both `rdata`=0xDEADBEEF one cycle later. Write x0=0xFFFFFFFF, then read x0 → 0.
- **Bypass:** same cycle `wren=1`, `waddr=3`, `wdata=0xA5A5A5A5`, `rden1=1`, `raddr1=3` → `rdata1`=0xA5A5A5A5 next cycle.
- **Scoreboard stall:** reserve x9, then hold `raddr2=9`, `rden2=1` → `busy2=1` each cycle. The cycle `wren=1`, `waddr=9`, `wdata=0x42` arrives → `busy2=0` that cycle, `rdata2`=0x42 next cycle.
- **Simultaneous reserve and write:** `rsv_en` + `wren` both on x4 in one cycle → `sb[4]` set afterwards; reading x4 shows `busy1=1`.
- **Configuration:** with `RV32E_EN`, write x20=0x55 and read x20 → 0. Reserve x20 → `busy1=0`.

Source files
------------

// File: rtl/register_file.sv
// Integer register file: two registered read ports, one write-back port and a pending-write
// scoreboard. Define RV32E_EN to shrink to 16 registers (x0-x15).
module register_file (
    input  logic        reset,
    input  logic        clock,
    input  logic        rden1,
    input  logic [4:0]  raddr1,
    input  logic        rden2,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        wren,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        rsv_en,
    input  logic [4:0]  rsv_addr,
    output logic        busy1,
    output logic        busy2
);

`ifdef RV32E_EN
    localparam int NREG = 16;
    localparam int AW   = 4;
`else
    localparam int NREG = 32;
    localparam int AW   = 5;
`endif

    logic [31:0]     regs_q [NREG];
    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [31:0]     rdata1_q;
    logic [31:0]     rdata1_d;
    logic [31:0]     rdata2_q;
    logic [31:0]     rdata2_d;

    logic          inRange1;
    logic          inRange2;
    logic          inRangeW;
    logic          inRangeRsv;
    logic          wrValid;
    logic          rsvValid;
    logic [AW-1:0] rIdx1;
    logic [AW-1:0] rIdx2;
    logic [AW-1:0] wIdx;
    logic [AW-1:0] rsvIdx;

    // Addresses above x15 are outside the reduced register set and behave as absent.
`ifdef RV32E_EN
    assign inRange1   = ~raddr1[4];
    assign inRange2   = ~raddr2[4];
    assign inRangeW   = ~waddr[4];
    assign inRangeRsv = ~rsv_addr[4];
`else
    assign inRange1   = 1'b1;
    assign inRange2   = 1'b1;
    assign inRangeW   = 1'b1;
    assign inRangeRsv = 1'b1;
`endif

    assign rIdx1  = raddr1[AW-1:0];
    assign rIdx2  = raddr2[AW-1:0];
    assign wIdx   = waddr[AW-1:0];
    assign rsvIdx = rsv_addr[AW-1:0];

    assign wrValid  = wren & (waddr != 5'd0) & inRangeW;
    assign rsvValid = rsv_en & (rsv_addr != 5'd0) & inRangeRsv;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wrValid) begin
            regs_q[wIdx] <= wdata;
        end
    end

    // Write-first bypass so a stalled reader picks up the retiring value one cycle later.
    always_comb begin
        rdata1_d = regs_q[rIdx1];
        if (!rden1 || raddr1 == 5'd0 || !inRange1) begin
            rdata1_d = '0;
        end else if (wrValid && waddr == raddr1) begin
            rdata1_d = wdata;
        end
    end

    always_comb begin
        rdata2_d = regs_q[rIdx2];
        if (!rden2 || raddr2 == 5'd0 || !inRange2) begin
            rdata2_d = '0;
        end else if (wrValid && waddr == raddr2) begin
            rdata2_d = wdata;
        end
    end

    // Reservation is applied after the clear: a newer producer outranks the retiring one.
    always_comb begin
        sb_d = sb_q;
        if (wren && inRangeW) begin
            sb_d[wIdx] = 1'b0;
        end
        if (rsvValid) begin
            sb_d[rsvIdx] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
            sb_q     <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            sb_q     <= sb_d;
        end
    end

    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;

    assign busy1 = rden1 & inRange1 & sb_q[rIdx1] & ~(wren & (waddr == raddr1));
    assign busy2 = rden2 & inRange2 & sb_q[rIdx2] & ~(wren & (waddr == raddr2));

endmodule
